// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, wait-state counter
// width and the latched request record.
package dmem_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dmem_req_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the core (master) and the data-memory responder
// (slave): valid/ready request channel plus valid/ready response channel.
interface dmem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word storage split into four byte lanes: combinational read of the whole
// word, clocked write of the enabled lanes. Contents are never reset.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [3:0]       lane_en,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (wr_en && lane_en[gi]) begin
               mem[idx] <= wdata[8*gi +: 8];
            end
         end

         assign rdata[8*gi +: 8] = mem[idx];
      end
   endgenerate

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// accesses dmem_array and returns a registered response. Optional macro
// DMEM_BYTE_STROBE_EN makes stores honour req_be; otherwise all lanes are written.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   dmem_state_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   dmem_req_t        req_reg, req_next;
   logic             req_ready_reg, req_ready_next;
   logic             rsp_valid_reg, rsp_valid_next;
   logic [31:0]      rdata_reg, rdata_next;
   logic             err_reg, err_next;

   logic             acc_err;
   logic             wr_en;
   logic [31:0]      rd_data;
   logic [3:0]       req_lanes;

   assign acc_err = (req_reg.addr[1:0] != 2'b00) ||
                    ({2'b00, req_reg.addr[31:2]} >= 32'(DEPTH));

   // The lane mask is resolved when the request is latched, so the write
   // path below is identical in both builds.
`ifdef DMEM_BYTE_STROBE_EN
   assign req_lanes = bus.req_be;
`else
   assign req_lanes = 4'hF;
`endif

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .lane_en (req_reg.be),
      .idx     (req_reg.addr[IDX_W+1:2]),
      .wdata   (req_reg.wdata),
      .rdata   (rd_data)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_next   = req_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      wr_en      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.req_valid && req_ready_reg) begin
               req_next.we    = bus.req_we;
               req_next.addr  = bus.req_addr;
               req_next.wdata = bus.req_wdata;
               req_next.be    = req_lanes;
               cnt_next       = CNT_W'(LATENCY);
               state_next     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               // Read data is sampled from the old contents while the
               // store (if any) lands on this same edge.
               err_next   = acc_err;
               rdata_next = (acc_err || req_reg.we) ? 32'h0 : rd_data;
               wr_en      = req_reg.we && !acc_err;
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rdata_next = 32'h0;
               err_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      req_ready_next = (state_next == IDLE);
      rsp_valid_next = (state_next == RESP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         req_reg       <= '0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rdata_reg     <= 32'h0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         req_reg       <= req_next;
         req_ready_reg <= req_ready_next;
         rsp_valid_reg <= rsp_valid_next;
         rdata_reg     <= rdata_next;
         err_reg       <= err_next;
      end
   end

   assign bus.req_ready = req_ready_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rdata_reg;
   assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized and directed bench for dmem_resp against a word-array reference
// model; honours DMEM_BYTE_STROBE_EN the same way the design build does.
module tb_dmem_resp;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

`ifdef DMEM_BYTE_STROBE_EN
   localparam logic [31:0] EXP_MERGE = 32'hAABBCC11;
`else
   localparam logic [31:0] EXP_MERGE = 32'h00000011;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;

   dmem_if bus ();

   dmem_resp #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] model_mem [DEPTH];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference behaviour: byte-addressed word memory with alignment/range errors.
   function automatic void model_access(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be,
                                        output logic [31:0] rd, output logic err);
      logic [29:0] widx;
      logic [3:0]  lanes;
      widx = addr[31:2];
      err  = (addr % 4 != 0) || (widx >= 30'(DEPTH));
      rd   = 32'h0;
`ifdef DMEM_BYTE_STROBE_EN
      lanes = be;
`else
      lanes = 4'hF;
`endif
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (lanes[b]) model_mem[widx[5:0]][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            rd = model_mem[widx[5:0]];
         end
      end
   endfunction

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic keep_valid);
      int k = 0;
      while (bus.req_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      @(posedge clk);
      @(negedge clk);
      if (!keep_valid) bus.req_valid = 1'b0;
      check_val("busy_after_accept", 32'(bus.req_ready), 32'd0);
   endtask

   task automatic wait_rsp();
      int k = 0;
      while (bus.rsp_valid !== 1'b1 && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check_val("rsp_latency", 32'(k), 32'(LAT + 1));
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, input logic keep_valid,
                         output logic [31:0] rd, output logic err);
      logic [31:0] exp_rd;
      logic        exp_err;
      model_access(we, addr, wdata, be, exp_rd, exp_err);
      issue(we, addr, wdata, be, keep_valid);
      wait_rsp();
      rd  = bus.rsp_rdata;
      err = bus.rsp_err;
      check_val("rdata", rd, exp_rd);
      check_val("err", 32'(err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check_val("hold_rdata", bus.rsp_rdata, exp_rd);
         check_val("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      check_val("ready_after_rsp", 32'(bus.req_ready), 32'd1);
      check_val("valid_clr", 32'(bus.rsp_valid), 32'd0);
      check_val("rdata_clr", bus.rsp_rdata, 32'h0);
      check_val("err_clr", 32'(bus.rsp_err), 32'd0);
      $display("txn we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d",
               we, addr, wdata, be, rd, err);
   endtask

   task automatic check_outputs_clear(input string tag);
      check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check_val({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
      check_val({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      logic [31:0] addr;
      int          sel;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_be    = 4'h0;
      bus.rsp_ready = 1'b0;

      // Power-on reset for three cycles.
      repeat (3) begin
         @(negedge clk);
         check_outputs_clear("in_reset");
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("ready_after_reset", 32'(bus.req_ready), 32'd1);

      // Store then load.
      do_txn(1'b1, 32'h64, 32'h19, 4'hF, 0, 1'b0, rd, err);
      do_txn(1'b0, 32'h64, 32'h0, 4'hF, 0, 1'b0, rd, err);
      check_val("load_0x64", rd, 32'h00000019);

      // Partial-lane store merge.
      do_txn(1'b1, 32'h60, 32'hAABBCCDD, 4'hF, 0, 1'b0, rd, err);
      do_txn(1'b1, 32'h60, 32'h00000011, 4'b0001, 0, 1'b0, rd, err);
      do_txn(1'b0, 32'h60, 32'h0, 4'hF, 0, 1'b0, rd, err);
      check_val("strobe_merge", rd, EXP_MERGE);

      // Misaligned and out-of-range accesses, then confirm nothing changed.
      do_txn(1'b0, 32'h62, 32'h0, 4'hF, 0, 1'b0, rd, err);
      check_val("misalign_err", 32'(err), 32'd1);
      do_txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, err);
      check_val("range_err", 32'(err), 32'd1);
      do_txn(1'b0, 32'h60, 32'h0, 4'hF, 0, 1'b0, rd, err);
      check_val("no_change", rd, EXP_MERGE);

      // Back-pressure for 5 cycles with req_valid left asserted.
      do_txn(1'b0, 32'h64, 32'h0, 4'hF, 5, 1'b1, rd, err);

      // Reset while a store sits in WAIT: store must be dropped.
      do_txn(1'b1, 32'h68, 32'h5, 4'hF, 0, 1'b0, rd, err);
      issue(1'b1, 32'h68, 32'hDEADBEEF, 4'hF, 1'b0);
      #2 reset = 1'b0;
      #1 check_outputs_clear("rst_wait");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("ready_after_rst_wait", 32'(bus.req_ready), 32'd1);
      check_val("no_rsp_after_rst_wait", 32'(bus.rsp_valid), 32'd0);
      do_txn(1'b0, 32'h68, 32'h0, 4'hF, 0, 1'b0, rd, err);
      check_val("store_dropped", rd, 32'h5);

      // Reset while a load response is being presented.
      issue(1'b0, 32'h68, 32'h0, 4'hF, 1'b0);
      wait_rsp();
      check_val("resp_before_rst", bus.rsp_rdata, 32'h5);
      #2 reset = 1'b0;
      #1 check_outputs_clear("rst_resp");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("ready_after_rst_resp", 32'(bus.req_ready), 32'd1);

      // Fill every word, then random traffic.
      for (int i = 0; i < DEPTH; i++) begin
         do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0, rd, err);
      end
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       addr = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
         else if (sel == 7) addr = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
         else               addr = 32'($urandom_range(DEPTH, 4000)) << 2;
         do_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd, err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
